// File: rtl/and_gate_sweeper.sv
// Stimulus generator and response checker for an N_IN-input AND gate.
// Drives all 2^N_IN input vectors in ascending order and holds each one for
// HOLD_CYC cycles. The gate output is compared against &vec in a one-cycle
// CHECK slot. The block reports pass/fail, a saturating mismatch count and
// the first failing vector.
// Optional build macro: AND_SWEEP_STOP_ON_FAIL_EN ends the sweep at the first mismatch.
module and_gate_sweeper #(
  parameter int unsigned N_IN     = 3,   // gate inputs driven, 1..8
  parameter int unsigned HOLD_CYC = 10,  // cycles each vector is held before sampling, >= 1
  parameter int unsigned CNT_W    = 8    // mismatch counter width
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [N_IN-1:0]  vec,
  input  logic             dut_y,
  output logic             exp_y,
  output logic [CNT_W-1:0] err_cnt,
  output logic [N_IN-1:0]  fail_vec
);

  // hold_cnt only ever reaches HOLD_CYC-1, so clog2(HOLD_CYC) bits suffice.
  localparam int unsigned HoldW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;

  localparam logic [HoldW-1:0] HoldLast = HoldW'(HOLD_CYC - 1);
  localparam logic [N_IN-1:0]  VecLast  = {N_IN{1'b1}};
  localparam logic [CNT_W-1:0] CntMax   = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    StIdle,
    StDrive,
    StCheck,
    StDone
  } state_e;

  state_e           state_q, state_d;
  logic [HoldW-1:0] hold_q, hold_d;
  logic [N_IN-1:0]  vec_q, vec_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic [N_IN-1:0]  fail_q, fail_d;
  logic             pass_q, pass_d;

  logic mismatch;
  logic sweep_end;

  // Expected response is purely combinational, so it tracks vec on the same cycle.
  assign exp_y    = &vec_q;
  assign mismatch = (dut_y != exp_y);

  // A sweep ends after the last vector, or at the first mismatch when stop-on-fail is built in.
`ifdef AND_SWEEP_STOP_ON_FAIL_EN
  assign sweep_end = (vec_q == VecLast) || mismatch;
`else
  assign sweep_end = (vec_q == VecLast);
`endif

  // Next-state logic: sequence the sweep and accumulate check results.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    vec_d   = vec_q;
    err_d   = err_q;
    fail_d  = fail_q;
    pass_d  = pass_q;

    unique case (state_q)
      // IDLE and DONE share the same start handling; a start clears all results.
      StIdle, StDone: begin
        if (start) begin
          state_d = StDrive;
          hold_d  = '0;
          vec_d   = '0;
          err_d   = '0;
          fail_d  = '0;
          pass_d  = 1'b0;
        end
      end

      // Hold the vector for HOLD_CYC cycles; start is ignored while busy.
      StDrive: begin
        if (hold_q == HoldLast) begin
          state_d = StCheck;
        end else begin
          hold_d = hold_q + HoldW'(1);
        end
      end

      // Single-cycle compare slot; dut_y is sampled on the edge that leaves this state.
      StCheck: begin
        if (mismatch) begin
          if (err_q != CntMax) begin
            err_d = err_q + CNT_W'(1);
          end
          // Capture only the first failing vector of the sweep.
          if (err_q == '0) begin
            fail_d = vec_q;
          end
        end

        hold_d = '0;
        if (sweep_end) begin
          state_d = StDone;
          vec_d   = '0;
          pass_d  = (err_d == '0);
        end else begin
          state_d = StDrive;
          vec_d   = vec_q + N_IN'(1);
        end
      end

      default: begin
        state_d = StIdle;
        hold_d  = '0;
        vec_d   = '0;
      end
    endcase
  end

  // State and result registers; the async reset clears every output without a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      hold_q  <= '0;
      vec_q   <= '0;
      err_q   <= '0;
      fail_q  <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      vec_q   <= vec_d;
      err_q   <= err_d;
      fail_q  <= fail_d;
      pass_q  <= pass_d;
    end
  end

  // Output decode from registered state.
  always_comb begin
    busy     = (state_q == StDrive) || (state_q == StCheck);
    done     = (state_q == StDone);
    pass     = pass_q;
    vec      = vec_q;
    err_cnt  = err_q;
    fail_vec = fail_q;
  end

endmodule

// File: tb/tb_and_gate_sweeper.sv
// Directed bench for and_gate_sweeper: table-driven gate models plus
// hand-written reset and extra-start sequences.
module tb_and_gate_sweeper;

  localparam int unsigned NIn  = 3;
  localparam int unsigned Hold = 10;

  logic           clk;
  logic           clk_en;
  logic           rst_n;
  logic           start;
  logic           dut_y;
  int             mode;

  logic           busy, done, pass, exp_y;
  logic [NIn-1:0] vec, fail_vec;
  logic [7:0]     err_cnt;

  logic           busy2, done2, pass2, exp_y2;
  logic [NIn-1:0] vec2, fail_vec2;
  logic [1:0]     err_cnt2;

  int checks;
  int errors;

  and_gate_sweeper #(
    .N_IN    (NIn),
    .HOLD_CYC(Hold),
    .CNT_W   (8)
  ) u_dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .busy    (busy),
    .done    (done),
    .pass    (pass),
    .vec     (vec),
    .dut_y   (dut_y),
    .exp_y   (exp_y),
    .err_cnt (err_cnt),
    .fail_vec(fail_vec)
  );

  // Narrow-counter instance runs in lockstep to exercise saturation.
  and_gate_sweeper #(
    .N_IN    (NIn),
    .HOLD_CYC(Hold),
    .CNT_W   (2)
  ) u_dut_sat (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .busy    (busy2),
    .done    (done2),
    .pass    (pass2),
    .vec     (vec2),
    .dut_y   (dut_y),
    .exp_y   (exp_y2),
    .err_cnt (err_cnt2),
    .fail_vec(fail_vec2)
  );

  initial clk = 1'b0;
  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  // Gate models: 0 ideal AND, 1 stuck-at-0, 2 stuck-at-1, 3 NAND, 4 OR.
  always_comb begin
    unique case (mode)
      1:       dut_y = 1'b0;
      2:       dut_y = 1'b1;
      3:       dut_y = ~(&vec);
      4:       dut_y = |vec;
      default: dut_y = &vec;
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_pass"}, 32'(pass), 0);
    check({tag, "_vec"}, 32'(vec), 0);
    check({tag, "_err_cnt"}, 32'(err_cnt), 0);
    check({tag, "_fail_vec"}, 32'(fail_vec), 0);
    check({tag, "_exp_y"}, 32'(exp_y), 0);
  endtask

  // Pulse start, check the accept state, then follow the sweep to DONE.
  // k counts edges after the accept edge; extra pulses start while vec=2.
  task automatic run_sweep(input int m, input bit extra, output int k);
    int bad;
    mode = m;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    check("accept_busy", 32'(busy), 1);
    check("accept_done", 32'(done), 0);
    check("accept_pass", 32'(pass), 0);
    check("accept_err_cnt", 32'(err_cnt), 0);
    check("accept_fail_vec", 32'(fail_vec), 0);
    k   = 0;
    bad = 0;
    while (done !== 1'b1 && k < 2000) begin
      if (int'(vec) != k / (Hold + 1)) bad++;
      if (exp_y !== (&vec)) bad++;
      if (extra && k == 25) start = 1'b1;
      if (extra && k == 26) start = 1'b0;
      @(negedge clk);
      k++;
    end
    check("vec_sequence", 32'(bad), 0);
    check("done_busy", 32'(busy), 0);
    check("done_vec", 32'(vec), 0);
  endtask

  typedef struct {
    int mode;
    int cyc;
    int err;
    int fv;
    bit pass;
  } vec_t;

  vec_t tbl[5];

  initial begin
    int k;
    int sat;

`ifdef AND_SWEEP_STOP_ON_FAIL_EN
    tbl[0] = '{mode: 0, cyc: 88, err: 0, fv: 0, pass: 1'b1};
    tbl[1] = '{mode: 1, cyc: 88, err: 1, fv: 7, pass: 1'b0};
    tbl[2] = '{mode: 2, cyc: 11, err: 1, fv: 0, pass: 1'b0};
    tbl[3] = '{mode: 3, cyc: 11, err: 1, fv: 0, pass: 1'b0};
    tbl[4] = '{mode: 4, cyc: 22, err: 1, fv: 1, pass: 1'b0};
`else
    tbl[0] = '{mode: 0, cyc: 88, err: 0, fv: 0, pass: 1'b1};
    tbl[1] = '{mode: 1, cyc: 88, err: 1, fv: 7, pass: 1'b0};
    tbl[2] = '{mode: 2, cyc: 88, err: 7, fv: 0, pass: 1'b0};
    tbl[3] = '{mode: 3, cyc: 88, err: 8, fv: 0, pass: 1'b0};
    tbl[4] = '{mode: 4, cyc: 88, err: 6, fv: 1, pass: 1'b0};
`endif

    checks = 0;
    errors = 0;
    clk_en = 1'b0;
    rst_n  = 1'b1;
    start  = 1'b0;
    mode   = 0;

    // Reset with the clock stopped.
    #3 rst_n = 1'b0;
    #2 check_cleared("reset_noclk");
    clk_en = 1'b1;
    @(negedge clk) rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("idle_busy", 32'(busy), 0);
    check("idle_done", 32'(done), 0);
    check("idle_vec", 32'(vec), 0);

    // Gate models; each sweep after the first also restarts from DONE.
    for (int i = 0; i < 5; i++) begin
      run_sweep(tbl[i].mode, 1'b0, k);
      check($sformatf("t%0d_cycles", i), 32'(k), 32'(tbl[i].cyc));
      check($sformatf("t%0d_done", i), 32'(done), 1);
      check($sformatf("t%0d_pass", i), 32'(pass), 32'(tbl[i].pass));
      check($sformatf("t%0d_err_cnt", i), 32'(err_cnt), 32'(tbl[i].err));
      check($sformatf("t%0d_fail_vec", i), 32'(fail_vec), 32'(tbl[i].fv));
      sat = (tbl[i].err > 3) ? 3 : tbl[i].err;
      check($sformatf("t%0d_err_cnt_sat", i), 32'(err_cnt2), 32'(sat));
    end

    // Asynchronous reset in the middle of vec=4.
    mode = 0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (47) @(negedge clk);
    check("mid_vec", 32'(vec), 4);
    check("mid_busy", 32'(busy), 1);
    rst_n = 1'b0;
    #1 check_cleared("reset_mid");
    @(negedge clk) rst_n = 1'b1;
    run_sweep(0, 1'b0, k);
    check("after_reset_cycles", 32'(k), 88);
    check("after_reset_pass", 32'(pass), 1);

    // Extra start while busy must not disturb the sweep.
    run_sweep(0, 1'b1, k);
    check("extra_start_cycles", 32'(k), 88);
    check("extra_start_pass", 32'(pass), 1);
    check("extra_start_err_cnt", 32'(err_cnt), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
